// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: requester-side bus and register-file write port of the write arbiter
interface regfile_wr_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]    Req;
   logic [5*NREQ-1:0]  WAddr;
   logic [32*NREQ-1:0] WData;
   logic [NREQ-1:0]    Gnt;
   logic [31:0]        D;
   logic [31:0]        En;
   logic               Busy;
   modport master (output Req, WAddr, WData, input Gnt, D, En, Busy);
   modport slave  (input Req, WAddr, WData, output Gnt, D, En, Busy);
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: merges NREQ writeback requesters onto the single register-file write port; REGFILE_ARB_FAIR_EN selects round-robin, otherwise fixed priority
module regfile_wr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input logic                 Clk,
   input logic                 Clrn,
   regfile_wr_arbiter_if.slave bus
);
   logic [NREQ-1:0] gnt_q, gnt_d, elig;
   logic [31:0]     d_q, d_d, en_q, en_d;
   logic            busy_q, busy_d;
   logic [IW-1:0]   ptr, win;
   logic [4:0]      waddr;
   logic            any;
   int              idx;

   // a requester being acknowledged this cycle still holds Req, so mask it out
   assign elig = bus.Req & ~gnt_q;

`ifdef REGFILE_ARB_FAIR_EN
   logic [IW-1:0] ptr_q, ptr_d;
   assign ptr_d = !any ? ptr_q : (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
   assign ptr   = ptr_q;
   // search start moves just past the last winner
   always_ff @(posedge Clk or negedge Clrn)
      if (!Clrn) ptr_q <= '0;
      else       ptr_q <= ptr_d;
`else
   assign ptr = '0;
`endif

   // first eligible index at or above ptr, wrapping at NREQ
   always_comb begin
      any = 1'b0;
      win = '0;
      idx = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any && elig[idx]) begin
            any = 1'b1;
            win = IW'(idx);
         end
      end
   end

   // write beat for the winner; address 0 still acknowledges but enables nothing
   always_comb begin
      waddr  = bus.WAddr[5*win +: 5];
      gnt_d  = any ? NREQ'(1) << win : '0;
      d_d    = any ? bus.WData[32*win +: 32] : d_q;
      en_d   = (any && waddr != 5'd0) ? 32'd1 << waddr : '0;
      busy_d = |(elig & ~gnt_d);
   end

   // registered write port; reset drops any beat in flight
   always_ff @(posedge Clk or negedge Clrn)
      if (!Clrn) begin
         gnt_q  <= '0;
         d_q    <= '0;
         en_q   <= '0;
         busy_q <= 1'b0;
      end else begin
         gnt_q  <= gnt_d;
         d_q    <= d_d;
         en_q   <= en_d;
         busy_q <= busy_d;
      end

   assign bus.Gnt  = gnt_q;
   assign bus.D    = d_q;
   assign bus.En   = en_q;
   assign bus.Busy = busy_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: scoreboard bench for regfile_wr_arbiter with a queue-based reference model
module tb_regfile_wr_arbiter;
   localparam int N = 4;
   logic Clk = 1'b0;
   logic Clrn = 1'b0;
   always #5 Clk = ~Clk;

   regfile_wr_arbiter_if #(.NREQ(N)) ifc ();
   regfile_wr_arbiter #(.NREQ(N)) dut (.Clk(Clk), .Clrn(Clrn), .bus(ifc));

   typedef struct {
      logic [N-1:0] g;
      logic [31:0]  d;
      logic [31:0]  e;
      logic         b;
   } exp_t;

   exp_t         q[$];
   int           vectors = 0;
   int           miscompares = 0;
   logic [N-1:0] m_gnt = '0;
   logic [31:0]  m_d = '0;
   int           m_ptr = 0;
   logic [31:0]  rf[32];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #2;
   endtask

   task automatic put(input int i, input logic [4:0] a, input logic [31:0] d);
      ifc.Req[i] = 1'b1;
      ifc.WAddr[5*i +: 5] = a;
      ifc.WData[32*i +: 32] = d;
   endtask

   task automatic model_reset();
      q.delete();
      m_gnt = '0;
      m_d = '0;
      m_ptr = 0;
   endtask

   // reference model: capture file writes, then predict the next beat from the request set
   always @(negedge Clk) begin
      int best;
      exp_t e;
      logic [N-1:0] el;
      if (Clrn) begin
         for (int j = 0; j < 32; j++) if (ifc.En[j]) rf[j] = ifc.D;
         el = ifc.Req & ~m_gnt;
         best = -1;
         for (int k = 0; k < N; k++)
            if (best < 0 && el[(m_ptr + k) % N]) best = (m_ptr + k) % N;
         e.g = (best >= 0) ? N'(1) << best : '0;
         e.d = (best >= 0) ? ifc.WData[32*best +: 32] : m_d;
         e.e = (best >= 0 && ifc.WAddr[5*best +: 5] != 5'd0) ? 32'd1 << ifc.WAddr[5*best +: 5] : '0;
         e.b = |(el & ~e.g);
         m_gnt = e.g;
         m_d = e.d;
`ifdef REGFILE_ARB_FAIR_EN
         if (best >= 0) m_ptr = (best + 1) % N;
`endif
         q.push_back(e);
      end
   end

   // monitor: every registered beat is compared against the oldest prediction
   always @(posedge Clk) begin
      exp_t e;
      #1;
      if (Clrn && q.size() > 0) begin
         e = q.pop_front();
         chk("sb_gnt", 32'(ifc.Gnt), 32'(e.g));
         chk("sb_d", ifc.D, e.d);
         chk("sb_en", ifc.En, e.e);
         chk("sb_busy", 32'(ifc.Busy), 32'(e.b));
      end
   end

   logic [N-1:0] rr_seq[5];
   logic [N-1:0] p02_seq[4];

   initial begin
`ifdef REGFILE_ARB_FAIR_EN
      rr_seq  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      p02_seq = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
`else
      rr_seq  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
      p02_seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`endif
      foreach (rf[j]) rf[j] = '0;
      ifc.Req = '0;
      ifc.WAddr = '0;
      ifc.WData = '0;
      cyc();
      cyc();
      Clrn = 1'b1;
      cyc();
      cyc();
      chk("idle_gnt", 32'(ifc.Gnt), 32'd0);
      chk("idle_en", ifc.En, 32'd0);
      chk("idle_d", ifc.D, 32'd0);
      chk("idle_busy", 32'(ifc.Busy), 32'd0);

      for (int i = 0; i < N; i++) put(i, 5'(10 + i), 32'hA000_0000 + 32'(i));
      for (int c = 0; c < 5; c++) begin
         cyc();
         chk("all_gnt", 32'(ifc.Gnt), 32'(rr_seq[c]));
         chk("all_busy", 32'(ifc.Busy), 32'd1);
         chk("all_en_onehot", 32'($countones(ifc.En)), 32'd1);
      end
      ifc.Req = '0;
      cyc();
      cyc();

      put(1, 5'd7, 32'hAAAA_0001);
      put(3, 5'd7, 32'hBBBB_0003);
      cyc();
      chk("race_gnt1", 32'(ifc.Gnt), 32'h2);
      chk("race_d1", ifc.D, 32'hAAAA_0001);
      ifc.Req[1] = 1'b0;
      cyc();
      chk("race_gnt3", 32'(ifc.Gnt), 32'h8);
      chk("race_en3", ifc.En, 32'h80);
      ifc.Req[3] = 1'b0;
      cyc();
      cyc();
      chk("race_rf7", rf[7], 32'hBBBB_0003);

      put(0, 5'd5, 32'hDEAD_BEEF);
      cyc();
      chk("single_gnt", 32'(ifc.Gnt), 32'h1);
      chk("single_en", ifc.En, 32'h20);
      chk("single_d", ifc.D, 32'hDEAD_BEEF);
      cyc();
      chk("single_mask", 32'(ifc.Gnt), 32'h0);
      ifc.Req[0] = 1'b0;
      cyc();
      chk("single_rf5", rf[5], 32'hDEAD_BEEF);

      put(1, 5'd0, 32'h0000_1234);
      cyc();
      chk("r0_gnt", 32'(ifc.Gnt), 32'h2);
      chk("r0_en", ifc.En, 32'h0);
      ifc.Req[1] = 1'b0;
      cyc();
      cyc();
      chk("r0_rf0", rf[0], 32'h0);

      put(0, 5'd3, 32'h3333_0000);
      put(2, 5'd4, 32'h4444_0002);
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk("p02_gnt", 32'(ifc.Gnt), 32'(p02_seq[c]));
      end
      ifc.Req = '0;
      cyc();
      cyc();

      put(2, 5'd8, 32'h8888_8888);
      cyc();
      chk("rst_pre_en", ifc.En, 32'h100);
      #1;
      Clrn = 1'b0;
      model_reset();
      #1;
      chk("rst_gnt", 32'(ifc.Gnt), 32'd0);
      chk("rst_en", ifc.En, 32'd0);
      chk("rst_d", ifc.D, 32'd0);
      chk("rst_busy", 32'(ifc.Busy), 32'd0);
      ifc.Req = '0;
      cyc();
      cyc();
      Clrn = 1'b1;
      cyc();
      cyc();
      chk("post_rst_en", ifc.En, 32'd0);
      chk("post_rst_d", ifc.D, 32'd0);

      for (int c = 0; c < 400; c++) begin
         cyc();
         for (int i = 0; i < N; i++) begin
            if (ifc.Gnt[i]) begin
               if ($urandom_range(0, 1) == 1) put(i, 5'($urandom_range(0, 31)), $urandom);
               else ifc.Req[i] = 1'b0;
            end else if (!ifc.Req[i] && $urandom_range(0, 2) == 0) begin
               put(i, 5'($urandom_range(0, 31)), $urandom);
            end
         end
      end
      ifc.Req = '0;
      cyc();
      cyc();
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
